// File: rtl/dmem_pkg.sv
// Shared decode constants, FSM encoding and lane helpers for the data-memory LSU.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] base_be(input size_t sz);
        case (sz)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Lanes landing in the addressed word; the *_hi variants give what spills into the next word.
    function automatic logic [3:0] be_lo(input size_t sz, input logic [1:0] off);
        return base_be(sz) << off;
    endfunction

    function automatic logic [3:0] be_hi(input size_t sz, input logic [1:0] off);
        return base_be(sz) >> (3'd4 - {1'b0, off});
    endfunction

    function automatic logic [31:0] data_lo(input logic [31:0] w, input logic [1:0] off);
        return w << {off, 3'b000};
    endfunction

    function automatic logic [31:0] data_hi(input logic [31:0] w, input logic [1:0] off);
        return w >> (6'd32 - {1'b0, off, 3'b000});
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input size_t sz, input logic uns);
        case (sz)
            SZ_B:    return uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            SZ_H:    return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/ram_be.sv
// 32-bit wide, DEPTH-word storage with synchronous read and per-byte write enables.
module ram_be #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing thousands of words would need a sweep FSM and
    // software never relies on power-up contents. Non-blocking writes keep read-old-data order.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: funct3 decode, lane steering, extension and optional misalign split.
// Define DMEM_MISALIGN_SPLIT_EN to execute misaligned halfword/word accesses as two beats.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DEPTH         = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_fault
);

    localparam int IDX_W = ADDRESS_WIDTH - 2;

    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_off;
    size_t            req_size;
    logic             req_legal;
    logic             req_mis;
    logic             req_fault;
    logic             accept;
    logic             rsp_next;

    logic [IDX_W-1:0] ram_idx;
    logic [3:0]       ram_be_w;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;

    logic             fault_q;
    logic             load_q;
    logic             uns_q;
    size_t            size_q;
    logic [1:0]       off_q;
    logic [31:0]      load_word;

    assign req_idx   = req_addr[ADDRESS_WIDTH-1:2];
    assign req_off   = req_addr[1:0];
    assign req_size  = f3_size(req_funct3);
    assign req_legal = f3_legal(req_we, req_funct3);
    assign req_mis   = misaligned(req_size, req_off);
    assign accept    = req_valid && req_ready;

`ifdef DMEM_MISALIGN_SPLIT_EN
    state_t           state;
    state_t           state_nxt;
    logic             go_split;
    logic             split_q;
    logic [IDX_W-1:0] idx2_q;
    logic [3:0]       be2_q;
    logic [31:0]      wdata2_q;
    logic [31:0]      lo_word_q;

    assign req_fault = !req_legal;
    assign go_split  = req_legal && req_mis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            split_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                split_q <= go_split;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept && go_split) state_nxt = S_SECOND;
            S_SECOND: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Gated on req_valid rather than accept: in IDLE the port is always ready.
    always_comb begin
        req_ready = (state == S_IDLE);
        ram_idx   = req_idx;
        ram_be_w  = 4'b0000;
        ram_wdata = data_lo(req_wdata, req_off);
        if (state == S_SECOND) begin
            ram_idx   = idx2_q;
            ram_be_w  = be2_q;
            ram_wdata = wdata2_q;
        end else if (req_valid && req_we && !req_fault) begin
            ram_be_w = be_lo(req_size, req_off);
        end
    end

    // Second-beat parameters; they are only consumed in SECOND so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx2_q   <= req_idx + 1'b1;
            be2_q    <= req_we ? be_hi(req_size, req_off) : 4'b0000;
            wdata2_q <= data_hi(req_wdata, req_off);
        end
        if (state == S_SECOND) begin
            lo_word_q <= ram_rdata;
        end
    end

    assign rsp_next  = (accept && !go_split) || (state == S_SECOND);
    assign load_word = split_q
        ? ((lo_word_q >> {off_q, 3'b000}) | (ram_rdata << (6'd32 - {1'b0, off_q, 3'b000})))
        : (ram_rdata >> {off_q, 3'b000});
`else
    assign req_fault = !req_legal || req_mis;
    assign req_ready = 1'b1;
    assign ram_idx   = req_idx;
    assign ram_be_w  = (req_valid && req_we && !req_fault) ? be_lo(req_size, req_off) : 4'b0000;
    assign ram_wdata = data_lo(req_wdata, req_off);
    assign rsp_next  = accept;
    assign load_word = ram_rdata >> {off_q, 3'b000};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            fault_q   <= 1'b0;
            load_q    <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= SZ_B;
            off_q     <= 2'b00;
        end else begin
            rsp_valid <= rsp_next;
            if (accept) begin
                fault_q <= req_fault;
                load_q  <= !req_we;
                uns_q   <= req_funct3[2];
                size_q  <= req_size;
                off_q   <= req_off;
            end
        end
    end

    assign rsp_fault = rsp_valid && fault_q;
    assign rsp_rdata = (rsp_valid && load_q && !fault_q) ? extend(load_word, size_q, uns_q) : 32'h0;

    ram_be #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_idx),
        .be    (ram_be_w),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu; expectations adapt to DMEM_MISALIGN_SPLIT_EN.
module tb_dmem_lsu;
    import dmem_pkg::*;

    localparam int AW = 14;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_fault;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          we;
        logic [2:0]    f3;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          exp_fault;
        logic [31:0]   exp_rdata;
        int            exp_lat;
    } vec_t;

    vec_t vecs[$];

    dmem_lsu #(
        .ADDRESS_WIDTH (AW),
        .DEPTH         (4096)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                                input logic [31:0] wdata, input logic exp_fault,
                                input logic [31:0] exp_rdata, input int exp_lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_fault = exp_fault; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic idle_req();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = 32'h0;
    endtask

    // One request, then wait (bounded) for its response and compare every attribute.
    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        @(negedge clk);
        check({tag, " ready_in"}, {31'b0, req_ready}, 32'd1);
        drive(v.we, v.f3, v.addr, v.wdata);
        @(negedge clk);
        idle_req();
        check({tag, " ready_after"}, {31'b0, req_ready}, (v.exp_lat == 2) ? 32'd0 : 32'd1);
        lat = 1;
        while (!rsp_valid && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " fault"}, {31'b0, rsp_fault}, {31'b0, v.exp_fault});
        check({tag, " rdata"}, rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_req();
        repeat (2) @(negedge clk);
        check("reset ready", {31'b0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_fault", {31'b0, rsp_fault}, 32'd0);
        reset = 1'b0;

        // Back-to-back SW then LW to the same word: latency 1 and read-after-write.
        @(negedge clk);
        drive(1'b1, F3_W, 14'h010, 32'hDEADBEEF);
        @(negedge clk);
        check("raw st valid", {31'b0, rsp_valid}, 32'd1);
        check("raw st fault", {31'b0, rsp_fault}, 32'd0);
        check("raw st rdata", rsp_rdata, 32'd0);
        drive(1'b0, F3_W, 14'h010, 32'h0);
        @(negedge clk);
        idle_req();
        check("raw ld valid", {31'b0, rsp_valid}, 32'd1);
        check("raw ld rdata", rsp_rdata, 32'hDEADBEEF);
        check("raw ld fault", {31'b0, rsp_fault}, 32'd0);
        @(negedge clk);
        check("raw pulse", {31'b0, rsp_valid}, 32'd0);

        // Clear the words whose full contents are compared later.
        vecs.push_back(mk(1, F3_W,  14'h000,  32'h0,        0, 32'h0, 1));
        vecs.push_back(mk(1, F3_W,  14'h3FFC, 32'h0,        0, 32'h0, 1));
        vecs.push_back(mk(1, F3_W,  14'h020,  32'h0,        0, 32'h0, 1));
        vecs.push_back(mk(1, F3_W,  14'h024,  32'h0,        0, 32'h0, 1));
        // Byte store and sign/zero loads.
        vecs.push_back(mk(1, F3_B,  14'h013,  32'h12345680, 0, 32'h0,        1));
        vecs.push_back(mk(0, F3_B,  14'h013,  32'h0,        0, 32'hFFFFFF80, 1));
        vecs.push_back(mk(0, F3_BU, 14'h013,  32'h0,        0, 32'h00000080, 1));
        vecs.push_back(mk(0, F3_W,  14'h010,  32'h0,        0, 32'h80ADBEEF, 1));
        // Halfword store leaves the low half intact.
        vecs.push_back(mk(1, F3_H,  14'h012,  32'hABCD1234, 0, 32'h0,        1));
        vecs.push_back(mk(0, F3_HU, 14'h012,  32'h0,        0, 32'h00001234, 1));
        vecs.push_back(mk(0, F3_W,  14'h010,  32'h0,        0, 32'h1234BEEF, 1));
        vecs.push_back(mk(0, F3_H,  14'h012,  32'h0,        0, 32'h00001234, 1));
        vecs.push_back(mk(0, F3_H,  14'h010,  32'h0,        0, 32'hFFFFBEEF, 1));
        vecs.push_back(mk(0, F3_HU, 14'h010,  32'h0,        0, 32'h0000BEEF, 1));
        vecs.push_back(mk(0, F3_B,  14'h011,  32'h0,        0, 32'hFFFFFFBE, 1));
        vecs.push_back(mk(0, F3_BU, 14'h010,  32'h0,        0, 32'h000000EF, 1));
        // Misaligned word at the last byte: split with wrap to word 0, or fault.
        vecs.push_back(mk(1, F3_W,  14'h3FFF, 32'hA1B2C3D4, !SPLIT, 32'h0, SPLIT ? 2 : 1));
        vecs.push_back(mk(0, F3_W,  14'h3FFF, 32'h0, !SPLIT, SPLIT ? 32'hA1B2C3D4 : 32'h0,
                          SPLIT ? 2 : 1));
        vecs.push_back(mk(0, F3_W,  14'h000,  32'h0, 0, SPLIT ? 32'h00A1B2C3 : 32'h0, 1));
        vecs.push_back(mk(0, F3_W,  14'h3FFC, 32'h0, 0, SPLIT ? 32'hD4000000 : 32'h0, 1));
        vecs.push_back(mk(0, F3_H,  14'h011,  32'h0, !SPLIT, SPLIT ? 32'h000034BE : 32'h0,
                          SPLIT ? 2 : 1));
        // Illegal funct3 codes fault without writing.
        vecs.push_back(mk(0, 3'b011, 14'h010, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(1, 3'b100, 14'h010, 32'hFFFFFFFF, 1, 32'h0, 1));
        vecs.push_back(mk(1, 3'b111, 14'h010, 32'hFFFFFFFF, 1, 32'h0, 1));
        vecs.push_back(mk(0, 3'b110, 14'h010, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(0, F3_W,   14'h010, 32'h0,        0, 32'h1234BEEF, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset pulsed while a split store sits in its second beat.
        @(negedge clk);
        drive(1'b1, F3_W, 14'h021, 32'hFFFFFFFF);
        @(negedge clk);
        idle_req();
        check("mid valid_before", {31'b0, rsp_valid}, {31'b0, !SPLIT});
        check("mid ready_before", {31'b0, req_ready}, {31'b0, !SPLIT});
        reset = 1'b1;
        #1;
        check("mid ready_in_reset", {31'b0, req_ready}, 32'd1);
        check("mid valid_in_reset", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid no_rsp", {31'b0, rsp_valid}, 32'd0);
        check("mid ready_after", {31'b0, req_ready}, 32'd1);
        run_vec("mid word8", mk(0, F3_W, 14'h020, 32'h0, 0, SPLIT ? 32'hFFFFFF00 : 32'h0, 1));
        run_vec("mid word9", mk(0, F3_W, 14'h024, 32'h0, 0, 32'h0, 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
